// File: rtl/instr_loader_pkg.sv
// Shared types and helpers for the boot-time instruction loader.
// Holds the loader state encoding, the length-field width and the bytes-per-word helper.
package instr_loader_pkg;

  localparam int LEN_W = 16;

  typedef enum logic [2:0] {
    S_LEN0,
    S_LEN1,
    S_DATA,
    S_CSUM,
    S_DONE,
    S_ERR
  } state_t;

  function automatic int bpw(input int n);
    return n / 8;
  endfunction

endpackage

// File: rtl/instr_loader_if.sv
// Byte-stream valid/ready channel from the host/UART side into the loader.
// A byte moves only on a clock edge where in_valid and in_ready are both high.
interface instr_loader_if;

  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);

endinterface

// File: rtl/instr_loader_byte_packer.sv
// Little-endian byte packer: each byte enters at the top and the word shifts right by 8.
// One-cycle update per shift; no backpressure of its own (shift_en is the only advance).
module byte_packer #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         shift_en,
  input  logic [7:0]   byte_in,
  output logic [N-1:0] word_out
);

  generate
    if (N == 8) begin : g_single
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          word_out <= '0;
        end else if (shift_en) begin
          word_out <= byte_in;
        end
      end
    end else begin : g_shift
      always_ff @(posedge clk) begin
        if (rst || clear) begin
          word_out <= '0;
        end else if (shift_en) begin
          word_out <= {byte_in, word_out[N-1:8]};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/instr_loader.sv
// Boot loader: frames LEN_LO, LEN_HI, L*N/8 data bytes into a flat N-bit word memory; done/error sticky.
// Word and done visible one cycle after the accepting byte; in_ready depends on state only.
// Optional trailing XOR checksum byte: INSTR_LOADER_CHECKSUM_EN.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int N = 32,
  parameter int M = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  instr_loader_if.slave         in_bus,
  output logic [N*(2**M)-1:0]   instructions,
  output logic [M:0]            words_loaded,
  output logic                  done,
  output logic                  error
);

  localparam int BPW   = bpw(N);
  localparam int DEPTH = 2**M;
  localparam int IDX_W = (BPW > 1) ? $clog2(BPW) : 1;

`ifdef INSTR_LOADER_CHECKSUM_EN
  localparam state_t S_AFTER = S_CSUM;
`else
  localparam state_t S_AFTER = S_DONE;
`endif

  state_t           state, state_nxt;
  logic             in_valid, in_ready, accept;
  logic [7:0]       in_data;
  logic [7:0]       len_lo;
  logic [LEN_W-1:0] len, len_in;
  logic             len_too_big;
  logic [IDX_W-1:0] byte_idx;
  logic             word_done, last_word;
  logic [LEN_W:0]   wl_next;
  logic [N-1:0]     packed_word, full_word;
  logic             unused_ok;
`ifdef INSTR_LOADER_CHECKSUM_EN
  logic [7:0]       csum;
`endif

  assign in_valid        = in_bus.in_valid;
  assign in_data         = in_bus.in_data;
  assign in_bus.in_ready = in_ready;

  assign in_ready = (state == S_LEN0) || (state == S_LEN1) ||
                    (state == S_DATA) || (state == S_CSUM);
  assign accept   = in_valid && in_ready;
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);

  assign len_in      = {in_data, len_lo};
  assign len_too_big = {1'b0, len_in} > (LEN_W+1)'(DEPTH);
  assign word_done   = (byte_idx == IDX_W'(BPW - 1));
  assign wl_next     = (LEN_W+1)'(words_loaded) + 1'b1;
  assign last_word   = (wl_next == {1'b0, len});

  byte_packer #(.N(N)) u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept && (state == S_LEN1)),
    .shift_en (accept && (state == S_DATA)),
    .byte_in  (in_data),
    .word_out (packed_word)
  );

  // The word is committed on the same edge as its last byte, so merge that byte in here.
  generate
    if (BPW == 1) begin : g_one
      assign full_word = in_data;
      assign unused_ok = ^packed_word;
    end else begin : g_multi
      assign full_word = {in_data, packed_word[N-1:8]};
      assign unused_ok = ^packed_word[7:0];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_LEN0;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_LEN0: if (accept) state_nxt = S_LEN1;
      S_LEN1: begin
        if (accept) begin
          if (len_in == '0)     state_nxt = S_AFTER;
          else if (len_too_big) state_nxt = S_ERR;
          else                  state_nxt = S_DATA;
        end
      end
      S_DATA: if (accept && word_done && last_word) state_nxt = S_AFTER;
`ifdef INSTR_LOADER_CHECKSUM_EN
      S_CSUM: if (accept) state_nxt = (in_data == csum) ? S_DONE : S_ERR;
`endif
      default: state_nxt = state;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_lo       <= '0;
      len          <= '0;
      byte_idx     <= '0;
      words_loaded <= '0;
      instructions <= '0;
`ifdef INSTR_LOADER_CHECKSUM_EN
      csum         <= '0;
`endif
    end else if (accept) begin
      case (state)
        S_LEN0: len_lo <= in_data;
        S_LEN1: len    <= len_in;
        S_DATA: begin
          if (word_done) begin
            byte_idx     <= '0;
            words_loaded <= words_loaded + 1'b1;
            instructions[int'(words_loaded[M-1:0]) * N +: N] <= full_word;
          end else begin
            byte_idx <= byte_idx + 1'b1;
          end
`ifdef INSTR_LOADER_CHECKSUM_EN
          csum <= csum ^ in_data;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Randomised scoreboard bench for instr_loader: frame-level reference model feeds expectation queues,
// a monitor pops them on every word write and on done/error.
module tb_instr_loader;

  localparam int N     = 32;
  localparam int M     = 10;
  localparam int BPW   = N / 8;
  localparam int DEPTH = 2**M;

  typedef struct { int idx; logic [N-1:0] val; } wexp_t;
  typedef struct { bit d; bit e; int wl; } stat_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [N*DEPTH-1:0]   instructions;
  logic [M:0]           words_loaded;
  logic                 done, error;

  instr_loader_if bus ();

  instr_loader #(.N(N), .M(M)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_bus       (bus),
    .instructions (instructions),
    .words_loaded (words_loaded),
    .done         (done),
    .error        (error)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0]   frame[$];
  wexp_t        word_q[$];
  stat_t        status_q[$];
  logic [N-1:0] model_mem [DEPTH];
  logic [N-1:0] snap [DEPTH];
  int           model_wl;
  bit           model_done, model_err;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < DEPTH; k++) model_mem[k] = '0;
    model_wl   = 0;
    model_done = 1'b0;
    model_err  = 1'b0;
  endtask

  // Reference: interpret the first lim bytes of frame as the spec's framing rules.
  task automatic model_frame(input int lim);
    int L, nw;
    logic [N-1:0] w, b;
    logic [7:0] cs;
    wexp_t we;
    stat_t st;
    if (lim < 2) return;
    L = int'(frame[0]) + 256 * int'(frame[1]);
    if (L > DEPTH) begin
      model_err = 1'b1;
      st.d = 1'b0; st.e = 1'b1; st.wl = 0;
      status_q.push_back(st);
      return;
    end
    nw = (lim - 2) / BPW;
    if (nw > L) nw = L;
    cs = 8'h00;
    for (int k = 0; k < nw; k++) begin
      w = '0;
      for (int j = 0; j < BPW; j++) begin
        b  = N'(frame[2 + k*BPW + j]);
        w  = w | (b << (8*j));
        cs = cs ^ frame[2 + k*BPW + j];
      end
      model_mem[k] = w;
      model_wl     = k + 1;
      we.idx = k; we.val = w;
      word_q.push_back(we);
    end
    if (nw == L) begin
`ifdef INSTR_LOADER_CHECKSUM_EN
      if (lim > 2 + L*BPW) begin
        if (frame[2 + L*BPW] == cs) model_done = 1'b1;
        else                        model_err  = 1'b1;
      end
`else
      model_done = 1'b1;
`endif
      if (model_done || model_err) begin
        st.d = model_done; st.e = model_err; st.wl = model_wl;
        status_q.push_back(st);
      end
    end
  endtask

  task automatic new_frame(input int L);
    frame.delete();
    frame.push_back(L[7:0]);
    frame.push_back(L[15:8]);
  endtask

  task automatic push_word(input logic [N-1:0] w);
    for (int j = 0; j < BPW; j++) frame.push_back(w[8*j +: 8]);
  endtask

  task automatic push_csum();
`ifdef INSTR_LOADER_CHECKSUM_EN
    logic [7:0] cs = 8'h00;
    for (int i = 2; i < frame.size(); i++) cs = cs ^ frame[i];
    frame.push_back(cs);
`endif
  endtask

  task automatic random_frame(input int L);
    new_frame(L);
    for (int i = 0; i < L*BPW; i++) frame.push_back(8'($urandom));
    push_csum();
  endtask

  // Called and returns on a negedge.
  task automatic send_bytes(input int lim, input bit gaps);
    for (int i = 0; i < lim; i++) begin
      if (gaps) begin
        repeat ($urandom_range(2, 0)) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
          @(negedge clk);
        end
      end
      bus.in_valid = 1'b1;
      bus.in_data  = frame[i];
      chk("in_ready_mid_frame", bus.in_ready, 1'b1);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic hold_invalid(input int n);
    repeat (n) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 8'($urandom);
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int mism = 0;
    chk({tag, "_done"}, done, model_done);
    chk({tag, "_error"}, error, model_err);
    chk({tag, "_words_loaded"}, words_loaded, model_wl);
    chk({tag, "_in_ready"}, bus.in_ready, !(model_done || model_err));
    for (int k = 0; k < DEPTH; k++)
      if (instructions[k*N +: N] !== model_mem[k]) mism++;
    chk({tag, "_mem_mismatches"}, mism, 0);
    chk({tag, "_pending_words"}, word_q.size(), 0);
    chk({tag, "_pending_status"}, status_q.size(), 0);
  endtask

  task automatic run_frame(input string tag, input int lim, input bit gaps);
    model_frame(lim);
    send_bytes(lim, gaps);
    check_all(tag);
    hold_invalid(4);
    check_all({tag, "_held"});
  endtask

  // A byte is presented during the reset cycle; it must not be taken as LEN_LO.
  task automatic do_reset();
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h01;
    @(negedge clk);
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
  endtask

  // Monitor: pops expectations whenever the DUT writes a word or reaches a terminal state.
  initial begin
    int    prev_wl;
    bit    prev_term;
    wexp_t we;
    stat_t st;
    prev_wl   = 0;
    prev_term = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (int'(words_loaded) == prev_wl + 1) begin
        if (word_q.size() == 0) begin
          chk("unexpected_word_write", words_loaded, prev_wl);
        end else begin
          we = word_q.pop_front();
          chk("mon_word_index", prev_wl, we.idx);
          chk($sformatf("mon_word%0d_value", we.idx), instructions[we.idx*N +: N], we.val);
        end
      end else if (int'(words_loaded) > prev_wl + 1) begin
        chk("mon_words_loaded_step", words_loaded, prev_wl + 1);
      end
      prev_wl = int'(words_loaded);
      if ((done || error) && !prev_term) begin
        if (status_q.size() == 0) begin
          chk("unexpected_terminal", {done, error}, 2'b00);
        end else begin
          st = status_q.pop_front();
          chk("mon_done", done, st.d);
          chk("mon_error", error, st.e);
          chk("mon_words_loaded", words_loaded, st.wl);
        end
      end
      prev_term = done || error;
    end
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("reset_instructions_zero", (instructions == '0), 1'b1);
    check_all("reset");

    // Two-word image from fixed bytes
    new_frame(2);
    push_word(32'h0000_0013);
    push_word(32'h1234_5678);
    push_csum();
    run_frame("t1", frame.size(), 1'b0);
    chk("t1_word0", instructions[0 +: N], 32'h0000_0013);
    chk("t1_word1", instructions[N +: N], 32'h1234_5678);
    chk("t1_word2", instructions[2*N +: N], 32'h0);

    // Empty image
    do_reset();
    new_frame(0);
    push_csum();
    run_frame("t2", frame.size(), 1'b0);

    // Oversized length: error after LEN_HI, nothing written
    do_reset();
    new_frame(16'h0401);
    run_frame("t3", 2, 1'b0);
    chk("t3_error", error, 1'b1);

    // Same random L=3 image with and without valid gaps
    do_reset();
    random_frame(3);
    run_frame("t4_nogap", frame.size(), 1'b0);
    for (int k = 0; k < DEPTH; k++) snap[k] = instructions[k*N +: N];
    do_reset();
    run_frame("t4_gap", frame.size(), 1'b1);
    begin
      int diff = 0;
      for (int k = 0; k < DEPTH; k++)
        if (instructions[k*N +: N] !== snap[k]) diff++;
      chk("t4_gap_vs_nogap", diff, 0);
    end

    // Reset after 6 data bytes of an L=4 load, then a fresh L=1 image
    do_reset();
    random_frame(4);
    model_frame(8);
    send_bytes(8, 1'b1);
    check_all("t5_partial");
    do_reset();
    check_all("t5_after_reset");
    new_frame(1);
    push_word(32'hDEAD_BEEF);
    push_csum();
    run_frame("t5_replay", frame.size(), 1'b0);
    chk("t5_word0", instructions[0 +: N], 32'hDEAD_BEEF);

`ifdef INSTR_LOADER_CHECKSUM_EN
    do_reset();
    new_frame(1);
    push_word(32'hDDCC_BBAA);
    frame.push_back(8'h00);
    run_frame("t6_good", frame.size(), 1'b0);
    chk("t6_good_done", done, 1'b1);
    do_reset();
    new_frame(1);
    push_word(32'hDDCC_BBAA);
    frame.push_back(8'h01);
    run_frame("t6_bad", frame.size(), 1'b1);
    chk("t6_bad_error", error, 1'b1);
    chk("t6_bad_word0", instructions[0 +: N], 32'hDDCC_BBAA);
`endif

    // Random images of assorted lengths
    for (int r = 0; r < 4; r++) begin
      do_reset();
      random_frame($urandom_range(8, 1));
      run_frame($sformatf("rand%0d", r), frame.size(), r[0]);
    end

    chk("final_word_q_empty", word_q.size(), 0);
    chk("final_status_q_empty", status_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
